bram_wb_sequencer: RTL and testbench
====================================

// Module: bram_wb_sequencer
// PURPOSE
//  Sequences and arbitrates the single port of the activation BRAM between two requesters.
//  - Layer write-back: a 28-element activation vector is captured and written to consecutive addresses from a base.
//  - Host port: single-beat reads/writes for image load and result readout.
//  Sits between the layer datapath (DPL outputs) and the bram_single instance; owns every BRAM control signal.
// PARAMETERS
//  N_ELEM  28  elements per write-back burst
//  DW      8   data width (signed two's complement activations)
//  AW      11  BRAM address width
// PORTS
//  clk          in   1          system clock, rising edge
//  rst_n        in   1          synchronous reset, active-low
//  wb_start     in   1          one-cycle pulse: capture wb_vec/wb_base, begin burst
//  wb_base      in   AW         first BRAM address of burst
//  wb_vec       in   N_ELEM*DW  packed vector, element i at [i*DW +: DW]
//  wb_busy      out  1          high while state != IDLE
//  wb_done      out  1          one-cycle pulse after last element written
//  host_req     in   1          host access request, level, held until granted
//  host_we      in   1          1=write, 0=read (qualified by host_req)
//  host_addr    in   AW         host address
//  host_wdata   in   DW         host write data
//  host_gnt     out  1          access performed this cycle (combinational)
//  host_rdata   out  DW         read data (= bram_do), valid when host_rvalid
//  host_rvalid  out  1          high exactly 1 cycle after a granted read
//  bram_en      out  1          BRAM enable
//  bram_we      out  1          BRAM write enable
//  bram_addr    out  AW         BRAM address
//  bram_di      out  DW         BRAM write data
//  bram_do      in   DW         BRAM read data, 1-cycle latency
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, idx=0, wb_done=0, host_rvalid=0, all bram_* outputs 0.
//    Capture buffer is not cleared. An aborted burst produces no wb_done.
//  - FSM IDLE -> WRITE -> DONE -> IDLE.
//    IDLE: wb_start=1 -> latch wb_vec into buf, wb_base into base, idx=0, go to WRITE.
//    WRITE: bram_en=1, bram_we=1, bram_addr=base+idx, bram_di=f(buf[idx]); idx++.
//      At idx==N_ELEM-1 the write occurs, then go to DONE.
//    DONE: wb_done=1 for exactly one cycle, then go to IDLE.
//  - Timing: wb_start at cycle 0; writes at cycles 1..28; wb_done at cycle 29.
//    Next wb_start is accepted at cycle 30.
//  - Address math is modulo 2^AW: base=2040 writes 2040..2047, then 0..19.
//  - wb_start while busy is ignored. The buffer is unchanged and the burst is not restarted.
//  - Host arbitration: host_gnt = host_req & (state==IDLE) & !wb_start.
//    Write-back always wins, including a same-cycle tie. Host waits at most N_ELEM+2 cycles.
//  - Granted host cycle: bram_en=1, bram_we=host_we, bram_addr=host_addr, bram_di=host_wdata.
//  - Granted read: host_rvalid=1 next cycle with host_rdata=bram_do.
//    Back-to-back granted reads give one rvalid per cycle.
//  - No grant and not WRITE: bram_en=0, bram_we=0, addr and di hold 0.
// CONFIGURATION
//  WB_RELU_EN defined:   f(x) = (x < 0) ? 0 : x, signed compare; writes are ReLU-clamped.
//  WB_RELU_EN undefined: f(x) = x, raw pass-through; host path is never clamped in either build.
// STRUCTURE
//  Shared package nn_ram_pkg holds:
//  - DW, AW, N_ELEM constants
//  - wb_state_t enum {IDLE, WRITE, DONE}
//  - relu8() function
//  No sub-module. FSM, buffer, arbiter and mux are flat in one module, about 150-200 lines.
// TESTING
//  1 Reset mid-burst: rst_n=0 at cycle 10 -> next cycle IDLE, bram_we=0, busy=0; no wb_done ever.
//  2 ReLU burst: vec[i]=i-14, base=100, WB_RELU_EN set -> addrs 100..127 written; 0 for i<14, i-14 otherwise; done at cycle 29.
//  3 Wrap: base=2040 -> 28 writes, last at addr 19; no ReLU build writes vec[27] raw (e.g. 8'hF3).
//  4 Tie: wb_start and host_req (read @5) same cycle -> host_gnt=0 for 30 cycles; granted cycle 30; rvalid cycle 31.
//  5 Host traffic: write 8'hA5 @7, then read @7 -> rvalid next cycle, rdata=8'hA5.
//  6 Busy restart: wb_start pulsed again at cycle 5 with new vec -> ignored; original data written; single wb_done.

Source files
------------

// File: rtl/nn_ram_pkg.sv
// Shared constants, FSM state type and activation clamp for the activation-BRAM sequencer.
package nn_ram_pkg;

  localparam int unsigned DW     = 8;
  localparam int unsigned AW     = 11;
  localparam int unsigned N_ELEM = 28;
  localparam int unsigned IDX_W  = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } wb_state_t;

  // Signed clamp at zero: negative two's-complement values become 0.
  function automatic logic [DW-1:0] relu8(input logic [DW-1:0] x);
    return x[DW-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/bram_wb_sequencer.sv
// Owns the single activation-BRAM port: 28-element layer write-back bursts plus host single beats.
// Optional ReLU clamp on burst data when WB_RELU_EN is defined; host data is never clamped.
module bram_wb_sequencer
  import nn_ram_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wb_start_i,
  input  logic [AW-1:0]          wb_base_i,
  input  logic [N_ELEM*DW-1:0]   wb_vec_i,
  output logic                   wb_busy_o,
  output logic                   wb_done_o,
  input  logic                   host_req_i,
  input  logic                   host_we_i,
  input  logic [AW-1:0]          host_addr_i,
  input  logic [DW-1:0]          host_wdata_i,
  output logic                   host_gnt_o,
  output logic [DW-1:0]          host_rdata_o,
  output logic                   host_rvalid_o,
  output logic                   bram_en_o,
  output logic                   bram_we_o,
  output logic [AW-1:0]          bram_addr_o,
  output logic [DW-1:0]          bram_di_o,
  input  logic [DW-1:0]          bram_do_i
);

  wb_state_t            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_ELEM*DW-1:0] buf_q;
  logic [AW-1:0]        base_q;
  logic                 rvalid_q, rvalid_d;
  logic                 capture;
  logic [DW-1:0]        elem;
  logic [DW-1:0]        elem_f;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wb_start_i) begin
          state_d = StWrite;
          idx_d   = '0;
          capture = 1'b1;
        end
      end
      StWrite: begin
        if (idx_q == IDX_W'(N_ELEM - 1)) begin
          state_d = StDone;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Capture registers are deliberately left out of reset; they are only read during a burst.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      buf_q  <= wb_vec_i;
      base_q <= wb_base_i;
    end
  end

  assign elem = buf_q[32'(idx_q)*DW +: DW];

`ifdef WB_RELU_EN
  assign elem_f = relu8(elem);
`else
  assign elem_f = elem;
`endif

  // Write-back always wins, including a same-cycle start.
  assign host_gnt_o = host_req_i & (state_q == StIdle) & ~wb_start_i;
  assign rvalid_d   = host_gnt_o & ~host_we_i;

  always_comb begin
    bram_en_o   = 1'b0;
    bram_we_o   = 1'b0;
    bram_addr_o = '0;
    bram_di_o   = '0;
    if (state_q == StWrite) begin
      bram_en_o   = 1'b1;
      bram_we_o   = 1'b1;
      bram_addr_o = base_q + AW'(idx_q);
      bram_di_o   = elem_f;
    end else if (host_gnt_o) begin
      bram_en_o   = 1'b1;
      bram_we_o   = host_we_i;
      bram_addr_o = host_addr_i;
      bram_di_o   = host_wdata_i;
    end
  end

  assign wb_busy_o     = (state_q != StIdle);
  assign wb_done_o     = (state_q == StDone);
  assign host_rvalid_o = rvalid_q;
  assign host_rdata_o  = bram_do_i;

endmodule

// File: tb/tb_bram_wb_sequencer.sv
// Directed bench for bram_wb_sequencer with a behavioural BRAM and write/read scoreboards.
module tb_bram_wb_sequencer;
  import nn_ram_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 wb_start = 1'b0;
  logic [AW-1:0]        wb_base = '0;
  logic [N_ELEM*DW-1:0] wb_vec = '0;
  logic                 wb_busy, wb_done;
  logic                 host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0]        host_addr = '0;
  logic [DW-1:0]        host_wdata = '0;
  logic                 host_gnt, host_rvalid;
  logic [DW-1:0]        host_rdata;
  logic                 bram_en, bram_we;
  logic [AW-1:0]        bram_addr;
  logic [DW-1:0]        bram_di;
  logic [DW-1:0]        bram_do = '0;

  logic [DW-1:0]        mem [2**AW];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_wr_data = '0;

  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]    rq[$];
  logic [AW+DW:0]   w_got, w_want;
  logic [DW:0]      r_got, r_want;

  bram_wb_sequencer u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wb_start_i   (wb_start),
    .wb_base_i    (wb_base),
    .wb_vec_i     (wb_vec),
    .wb_busy_o    (wb_busy),
    .wb_done_o    (wb_done),
    .host_req_i   (host_req),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_gnt_o   (host_gnt),
    .host_rdata_o (host_rdata),
    .host_rvalid_o(host_rvalid),
    .bram_en_o    (bram_en),
    .bram_we_o    (bram_we),
    .bram_addr_o  (bram_addr),
    .bram_di_o    (bram_di),
    .bram_do_i    (bram_do)
  );

  always #5 clk_i = ~clk_i;

  // Read-first single-port BRAM, one-cycle read latency.
  always @(posedge clk_i) begin
    if (bram_en === 1'b1) begin
      if (bram_we === 1'b1) mem[bram_addr] <= bram_di;
      bram_do <= mem[bram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [DW-1:0] fexp(input logic [DW-1:0] x);
`ifdef WB_RELU_EN
    return ($signed(x) < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  // Scoreboard side: burst writes and host read data popped as the DUT produces them.
  always @(negedge clk_i) begin
    if (bram_en === 1'b1 && bram_we === 1'b1 && host_gnt === 1'b0) begin
      w_got  = {1'b1, bram_addr, bram_di};
      w_want = (wq.size() > 0) ? {1'b1, wq.pop_front()} : '0;
      chk("burst_write", 32'(w_got), 32'(w_want));
      last_wr_addr = bram_addr;
      last_wr_data = bram_di;
    end
    if (host_rvalid === 1'b1) begin
      r_got  = {1'b1, host_rdata};
      r_want = (rq.size() > 0) ? {1'b1, rq.pop_front()} : '0;
      chk("host_rdata", 32'(r_got), 32'(r_want));
    end
    if (wb_done === 1'b1) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Called at cycle 0 (#1 after an edge); returns at cycle 1.
  task automatic start_burst(input logic [AW-1:0] base, input logic [N_ELEM*DW-1:0] vec,
                             input int n_expect);
    wb_start = 1'b1;
    wb_base  = base;
    wb_vec   = vec;
    for (int i = 0; i < n_expect; i++) wq.push_back({AW'(base + AW'(i)), fexp(vec[i*DW +: DW])});
    @(posedge clk_i); #1;
    wb_start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = -1;
    for (int c = c0; c < c0 + 60; c++) begin
      @(negedge clk_i);
      if (wb_done === 1'b1) begin
        cyc = c;
        @(posedge clk_i); #1;
        break;
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bit got;
    got = 1'b0;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (host_gnt === 1'b1) begin got = 1'b1; break; end
      @(posedge clk_i); #1;
    end
    if (!got) chk("host_gnt_timeout", 32'(got), 32'd1);
    @(posedge clk_i); #1;
    host_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    logic [N_ELEM*DW-1:0] va, vb;
    int cyc, first, done_c, d0;

    // Reset state
    idle(2);
    @(negedge clk_i);
    chk("rst_busy",   32'(wb_busy), 0);
    chk("rst_done",   32'(wb_done), 0);
    chk("rst_rvalid", 32'(host_rvalid), 0);
    chk("rst_en",     32'(bram_en), 0);
    chk("rst_we",     32'(bram_we), 0);
    chk("rst_addr",   32'(bram_addr), 0);
    chk("rst_di",     32'(bram_di), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle(1);

    // Host traffic, read-after-write and back-to-back reads
    host_op(1'b1, 11'd7, 8'hA5);
    host_op(1'b1, 11'd5, 8'h3C);
    rq.push_back(8'hA5);
    host_op(1'b0, 11'd7, 8'h00);
    @(negedge clk_i);
    chk("rvalid_after_read", 32'(host_rvalid), 1);
    @(posedge clk_i); #1;
    rq.push_back(8'hA5);
    rq.push_back(8'h3C);
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'd7;
    @(negedge clk_i);
    chk("b2b_gnt0", 32'(host_gnt), 1);
    @(posedge clk_i); #1;
    host_addr = 11'd5;
    @(negedge clk_i);
    chk("b2b_gnt1", 32'(host_gnt), 1);
    chk("b2b_rvalid0", 32'(host_rvalid), 1);
    @(posedge clk_i); #1;
    host_req = 1'b0;
    @(negedge clk_i);
    chk("b2b_rvalid1", 32'(host_rvalid), 1);
    @(posedge clk_i); #1;
    idle(1);

    // Tie: write-back start and host read in the same cycle
    for (int i = 0; i < N_ELEM; i++) va[i*DW +: DW] = DW'($urandom);
    wb_start = 1'b1; wb_base = 11'd200; wb_vec = va;
    for (int i = 0; i < N_ELEM; i++) wq.push_back({AW'(200 + i), fexp(va[i*DW +: DW])});
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'd5;
    rq.push_back(8'h3C);
    first = -1; done_c = -1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk_i);
      if (host_gnt === 1'b1 && first < 0) first = c;
      if (first >= 0 && c == first + 1) chk("tie_rvalid", 32'(host_rvalid), 1);
      if (wb_done === 1'b1) done_c = c;
      @(posedge clk_i); #1;
      wb_start = 1'b0;
      if (first >= 0) host_req = 1'b0;
      if (first >= 0 && c > first) break;
    end
    host_req = 1'b0;
    chk("tie_first_gnt", 32'(first), 32'd30);
    chk("tie_done_cycle", 32'(done_c), 32'd29);
    idle(1);

    // Burst with negative and positive elements
    for (int i = 0; i < N_ELEM; i++) va[i*DW +: DW] = DW'(i - 14);
    d0 = done_cnt;
    start_burst(11'd100, va, N_ELEM);
    @(negedge clk_i);
    chk("burst_busy", 32'(wb_busy), 1);
    @(posedge clk_i); #1;
    wait_done(2, cyc);
    chk("burst_done_cycle", 32'(cyc), 32'd29);
    chk("burst_wq_empty", 32'(wq.size()), 0);
    chk("burst_last_data", 32'(last_wr_data), 32'(fexp(8'd13)));
    @(negedge clk_i);
    chk("burst_idle_after", 32'(wb_busy), 0);
    chk("burst_done_count", 32'(done_cnt - d0), 1);
    @(posedge clk_i); #1;

    // Start while busy must be ignored
    for (int i = 0; i < N_ELEM; i++) va[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < N_ELEM; i++) vb[i*DW +: DW] = ~va[i*DW +: DW];
    d0 = done_cnt;
    start_burst(11'd300, va, N_ELEM);
    idle(4);
    wb_start = 1'b1; wb_base = 11'd400; wb_vec = vb;
    @(posedge clk_i); #1;
    wb_start = 1'b0;
    wait_done(6, cyc);
    chk("restart_done_cycle", 32'(cyc), 32'd29);
    idle(5);
    chk("restart_done_count", 32'(done_cnt - d0), 1);
    chk("restart_wq_empty", 32'(wq.size()), 0);

    // Address wrap with a negative final element
    for (int i = 0; i < N_ELEM; i++) va[i*DW +: DW] = DW'($urandom);
    va[27*DW +: DW] = 8'hF3;
    start_burst(11'd2040, va, N_ELEM);
    wait_done(1, cyc);
    chk("wrap_done_cycle", 32'(cyc), 32'd29);
    chk("wrap_last_addr", 32'(last_wr_addr), 32'd19);
    chk("wrap_last_data", 32'(last_wr_data), 32'(fexp(8'hF3)));
    chk("wrap_wq_empty", 32'(wq.size()), 0);
    idle(1);

    // Reset in the middle of a burst
    d0 = done_cnt;
    for (int i = 0; i < N_ELEM; i++) va[i*DW +: DW] = DW'($urandom);
    start_burst(11'd500, va, 10);
    idle(9);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("abort_busy", 32'(wb_busy), 0);
    chk("abort_we", 32'(bram_we), 0);
    chk("abort_en", 32'(bram_en), 0);
    @(posedge clk_i); #1;
    idle(40);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_wq_empty", 32'(wq.size()), 0);
    chk("final_rq_empty", 32'(rq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
